load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: takes one memory op from the ALU stage, issues a single
// aligned data-memory request, and writes sign/zero-extended load data back.
module load_store_unit #(
    parameter int cXLEN       = 32,
    parameter int cRegSelBitW = 5
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic                   iMemDv,
    input  logic                   iRead,
    input  logic                   iWrite,
    input  logic [cXLEN-1:0]       iAddr,
    input  logic [cXLEN-1:0]       iData,
    input  logic [2:0]             iOpType,
    input  logic [cRegSelBitW-1:0] iRdAddr,
    output logic                   oBusy,
    output logic                   oMemReq,
    output logic                   oMemWe,
    output logic [cXLEN-1:0]       oMemAddr,
    output logic [cXLEN-1:0]       oMemWData,
    output logic [cXLEN/8-1:0]     oMemBe,
    input  logic                   iMemAck,
    input  logic [cXLEN-1:0]       iMemRData,
    output logic                   oRegDv,
    output logic [cRegSelBitW-1:0] oRegAddr,
    output logic [cXLEN-1:0]       oRegData,
    output logic                   oFault,
    output logic [1:0]             oDbgState
);

    localparam int cBeW = cXLEN / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WB   = 2'd2
    } state_t;

    // Handshake: an op is taken on an edge where iMemDv=1 and the unit is IDLE;
    // oBusy=1 means upstream must hold its op. The memory side sees oMemReq held
    // with stable address/data/enables until the edge that samples iMemAck=1.

    state_t state;
    state_t stateNext;

    logic                   memReqQ;
    logic                   memWeQ;
    logic [cXLEN-1:0]       memAddrQ;
    logic [cXLEN-1:0]       memWDataQ;
    logic [cBeW-1:0]        memBeQ;
    logic                   regDvQ;
    logic [cRegSelBitW-1:0] regAddrQ;
    logic [cXLEN-1:0]       regDataQ;
    logic                   faultQ;
    logic [2:0]             ldOpQ;
    logic [1:0]             ldOffQ;

    logic             opIsLoad;
    logic             opIsStore;
    logic             f3Legal;
    logic             misaligned;
    logic             opLegal;
    logic [cBeW-1:0]  reqBe;
    logic [cXLEN-1:0] reqWData;
    logic [cXLEN-1:0] rdShifted;
    logic [cXLEN-1:0] ldExt;

    // Accept-side decode: legality, byte lanes and replicated store data.
    always_comb begin
        opIsLoad   = iRead & ~iWrite;
        opIsStore  = iWrite & ~iRead;
        f3Legal    = 1'b0;
        misaligned = 1'b0;
        reqBe      = '0;
        reqWData   = '0;

        if (opIsLoad) begin
            case (iOpType)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3Legal = 1'b1;
                default:                                f3Legal = 1'b0;
            endcase
        end else if (opIsStore) begin
            case (iOpType)
                3'b000, 3'b001, 3'b010: f3Legal = 1'b1;
                default:                f3Legal = 1'b0;
            endcase
        end

        case (iOpType[1:0])
            2'b01:   misaligned = iAddr[0];
            2'b10:   misaligned = (iAddr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase

        case (iOpType[1:0])
            2'b00: begin
                reqBe    = cBeW'(1) << iAddr[1:0];
                reqWData = {(cXLEN/8){iData[7:0]}};
            end
            2'b01: begin
                reqBe    = cBeW'(3) << iAddr[1:0];
                reqWData = {(cXLEN/16){iData[15:0]}};
            end
            default: begin
                reqBe    = cBeW'(15);
                reqWData = iData;
            end
        endcase

        if (!opIsStore) begin
            reqWData = '0;
        end

        opLegal = f3Legal & ~misaligned;
    end

    // Lane select and extension of the returned read word.
    always_comb begin
        rdShifted = iMemRData >> {ldOffQ, 3'b000};
        case (ldOpQ)
            3'b000:  ldExt = {{(cXLEN-8){rdShifted[7]}}, rdShifted[7:0]};
            3'b001:  ldExt = {{(cXLEN-16){rdShifted[15]}}, rdShifted[15:0]};
            3'b100:  ldExt = {{(cXLEN-8){1'b0}}, rdShifted[7:0]};
            3'b101:  ldExt = {{(cXLEN-16){1'b0}}, rdShifted[15:0]};
            default: ldExt = rdShifted;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (iMemDv && opLegal) stateNext = REQ;
            REQ:     if (iMemAck) stateNext = memWeQ ? IDLE : WB;
            WB:      stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            memReqQ   <= 1'b0;
            memWeQ    <= 1'b0;
            memAddrQ  <= '0;
            memWDataQ <= '0;
            memBeQ    <= '0;
            regDvQ    <= 1'b0;
            regAddrQ  <= '0;
            regDataQ  <= '0;
            faultQ    <= 1'b0;
            ldOpQ     <= '0;
            ldOffQ    <= '0;
        end else begin
            faultQ <= 1'b0;
            regDvQ <= 1'b0;
            if (state == IDLE && iMemDv) begin
                if (opLegal) begin
                    memReqQ   <= 1'b1;
                    memWeQ    <= opIsStore;
                    memAddrQ  <= {iAddr[cXLEN-1:2], 2'b00};
                    memWDataQ <= reqWData;
                    memBeQ    <= reqBe;
                    regAddrQ  <= iRdAddr;
                    ldOpQ     <= iOpType;
                    ldOffQ    <= iAddr[1:0];
                end else begin
                    faultQ <= 1'b1;
                end
            end
            if (state == REQ && iMemAck) begin
                memReqQ <= 1'b0;
                if (!memWeQ) begin
                    regDataQ <= ldExt;
                    // x0 is never written, but the access itself still happens.
                    regDvQ   <= (regAddrQ != '0);
                end
            end
        end
    end

    assign oBusy     = (state != IDLE);
    assign oMemReq   = memReqQ;
    assign oMemWe    = memWeQ;
    assign oMemAddr  = memAddrQ;
    assign oMemWData = memWDataQ;
    assign oMemBe    = memBeQ;
    assign oRegDv    = regDvQ;
    assign oRegAddr  = regAddrQ;
    assign oRegData  = regDataQ;
    assign oFault    = faultQ;
    assign oDbgState = state;

endmodule
